timing_sequencer: RTL and testbench
===================================

TIMING_SEQUENCER -- requirements
Module: timing_sequencer

Interface
REQ-001 Parameter WAIT_LIMIT, default 64, range 1..255: maximum cycles spent in one bus-wait state before fault.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 run  input  1  enable instruction sequencing; sampled at instruction boundaries only.
REQ-005 output_done  input  1  phase-complete from control logic; sampled only in wait states.
REQ-006 mem_op  input  1  current instruction is SW or LW; sampled only in EX1.
REQ-007 Mif  output  1  instruction-fetch machine cycle (IF1 or IF2).
REQ-008 Mex  output  1  execute machine cycle (EX1..EX4).
REQ-009 T1_Mif, T2_Mif  output  1 each  fetch timing states (IF1, IF2).
REQ-010 T1, T2, T3, T4  output  1 each  execute timing states (EX1..EX4).
REQ-011 busy  output  1  high in any state except IDLE and FAULT.
REQ-012 fault  output  1  bus-wait timeout occurred; sticky until reset.
REQ-013 retired_count  output  16  count of completed instructions.

Function
REQ-014 FSM states SHALL be IDLE, IF1, IF2, EX1, EX2, EX3, EX4, FAULT, held in a registered state; all timing outputs decode combinationally from it, exactly one of T1_Mif/T2_Mif/T1..T4 high in non-IDLE/non-FAULT states, none otherwise.
REQ-015 Mif SHALL equal T1_Mif|T2_Mif; Mex SHALL equal T1|T2|T3|T4; Mif and Mex never high together.
REQ-016 "Next-fetch" target SHALL be IF1 if run=1, else IDLE.
REQ-017 IDLE: run=1 -> IF1 next cycle; else stay.
REQ-018 IF1 SHALL last exactly one cycle (bus start and PC increment) -> IF2 unconditionally; output_done ignored.
REQ-019 IF2: output_done=1 -> EX1; else stay, subject to timeout.
REQ-020 EX1: mem_op=1 -> EX2; mem_op=0 -> next-fetch target, retired_count increments.
REQ-021 EX2 SHALL last exactly one cycle (bus start) -> EX3 unconditionally.
REQ-022 EX3: output_done=1 -> EX4; else stay, subject to timeout.
REQ-023 EX4 SHALL last one cycle -> next-fetch target; retired_count increments.
REQ-024 Minimum instruction latency: non-memory 3 cycles (IF1, IF2 with done, EX1); memory 6 cycles when done arrives on first wait cycle.
REQ-025 wait_cnt (8-bit internal) SHALL clear on entry to IF2/EX3 and increment each cycle spent there with output_done=0.
REQ-026 When in IF2/EX3 with output_done=0 and wait_cnt = WAIT_LIMIT-1, next state SHALL be FAULT; output_done=1 on that same cycle wins (normal transition, no fault).
REQ-027 FAULT SHALL be terminal: fault=1, busy=0, all timing outputs 0, run ignored, exit only via rst.
REQ-028 retired_count SHALL wrap 0xFFFF -> 0x0000 without other effect.
REQ-029 run deasserting mid-instruction SHALL NOT abort it; the instruction completes and the FSM then enters IDLE.
REQ-030 output_done in IF1, EX1, EX2, EX4, IDLE SHALL have no effect.

Reset
REQ-031 rst=1 SHALL immediately (asynchronously) force state IDLE, wait_cnt 0, retired_count 0, fault 0; hence all outputs 0.
REQ-032 rst asserted mid-operation (any state, including wait states) SHALL abandon the instruction with no increment; after release the FSM waits in IDLE for run.

Verification
REQ-033 rst release, run=1, mem_op=0, output_done=1 from IF2 onward -> state sequence IF1,IF2,EX1,IF1,...; retired_count=1 after cycle 3, =3 after cycle 9.
REQ-034 mem_op=1, output_done pulses on 3rd EX3 cycle -> T1,T2,T3,T3,T3,T4 then T1_Mif; retired_count +1.
REQ-035 WAIT_LIMIT=4, output_done held 0 in IF2 -> 4 cycles of T2_Mif, then fault=1, busy=0, all T outputs 0 until rst.
REQ-036 WAIT_LIMIT=4, output_done=1 on 4th IF2 cycle -> EX1, fault stays 0.
REQ-037 run dropped during EX3 -> EX3 completes, EX4, then IDLE with busy=0; run reasserted -> IF1 next cycle.
REQ-038 retired_count preset by running 65535 instructions, one more -> 0x0000; rst asserted during EX3 -> all outputs 0 the same cycle, count 0.

Source files
------------

// File: rtl/timing_sequencer_if.sv
// rtl/timing_sequencer_if.sv - control/status bundle between the sequencer and its control logic
interface timing_sequencer_if;
  logic        run;
  logic        output_done;
  logic        mem_op;
  logic        Mif;
  logic        Mex;
  logic        T1_Mif;
  logic        T2_Mif;
  logic        T1;
  logic        T2;
  logic        T3;
  logic        T4;
  logic        busy;
  logic        fault;
  logic [15:0] retired_count;

  modport master (
    output run, output_done, mem_op,
    input  Mif, Mex, T1_Mif, T2_Mif, T1, T2, T3, T4, busy, fault, retired_count
  );

  modport slave (
    input  run, output_done, mem_op,
    output Mif, Mex, T1_Mif, T2_Mif, T1, T2, T3, T4, busy, fault, retired_count
  );
endinterface

// File: rtl/timing_sequencer.sv
// rtl/timing_sequencer.sv - fetch/execute timing-state sequencer with bus-wait timeout
module timing_sequencer #(
  parameter int WAIT_LIMIT = 64
) (
  input  logic              clk,
  input  logic              rst,
  timing_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_IF1   = 3'd1,
    S_IF2   = 3'd2,
    S_EX1   = 3'd3,
    S_EX2   = 3'd4,
    S_EX3   = 3'd5,
    S_EX4   = 3'd6,
    S_FAULT = 3'd7
  } state_t;

  // Last wait cycle allowed before the bus is declared dead.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] retired_count_q, retired_count_d;
  state_t      fetch_target;
  logic        wait_expired;

  // run only matters at an instruction boundary, where it picks the next fetch.
  assign fetch_target = bus.run ? S_IF1 : S_IDLE;
  assign wait_expired = (wait_cnt_q == WAIT_LAST);

  // Next-state decode; output_done only counts in IF2/EX3, and a done on the
  // final permitted wait cycle still beats the timeout.
  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    retired_count_d = retired_count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_IF1;
      end
      S_IF1: begin
        state_d    = S_IF2;
        wait_cnt_d = '0;
      end
      S_IF2: begin
        if (bus.output_done)   state_d = S_EX1;
        else if (wait_expired) state_d = S_FAULT;
        else                   wait_cnt_d = wait_cnt_q + 8'd1;
      end
      S_EX1: begin
        if (bus.mem_op) begin
          state_d = S_EX2;
        end else begin
          state_d         = fetch_target;
          retired_count_d = retired_count_q + 16'd1;
        end
      end
      S_EX2: begin
        state_d    = S_EX3;
        wait_cnt_d = '0;
      end
      S_EX3: begin
        if (bus.output_done)   state_d = S_EX4;
        else if (wait_expired) state_d = S_FAULT;
        else                   wait_cnt_d = wait_cnt_q + 8'd1;
      end
      S_EX4: begin
        state_d         = fetch_target;
        retired_count_d = retired_count_q + 16'd1;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  // State and counters; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      wait_cnt_q      <= '0;
      retired_count_q <= '0;
    end else begin
      state_q         <= state_d;
      wait_cnt_q      <= wait_cnt_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign bus.T1_Mif        = (state_q == S_IF1);
  assign bus.T2_Mif        = (state_q == S_IF2);
  assign bus.T1            = (state_q == S_EX1);
  assign bus.T2            = (state_q == S_EX2);
  assign bus.T3            = (state_q == S_EX3);
  assign bus.T4            = (state_q == S_EX4);
  assign bus.Mif           = bus.T1_Mif | bus.T2_Mif;
  assign bus.Mex           = bus.T1 | bus.T2 | bus.T3 | bus.T4;
  assign bus.fault         = (state_q == S_FAULT);
  assign bus.busy          = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign bus.retired_count = retired_count_q;

endmodule

// File: tb/tb_timing_sequencer.sv
// tb/tb_timing_sequencer.sv - directed and randomized bench for timing_sequencer
module tb_timing_sequencer;

  localparam int P_IDLE  = 0;
  localparam int P_IF1   = 1;
  localparam int P_IF2   = 2;
  localparam int P_EX1   = 3;
  localparam int P_EX2   = 4;
  localparam int P_EX3   = 5;
  localparam int P_EX4   = 6;
  localparam int P_FAULT = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int passed = 0;
  int total  = 0;
  logic [15:0] model_cnt = 16'd0;
  string pname [8] = '{"idle", "if1", "if2", "ex1", "ex2", "ex3", "ex4", "fault"};

  timing_sequencer_if bus ();

  timing_sequencer #(.WAIT_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Expected {fault,busy,Mif,Mex,T1_Mif,T2_Mif,T1,T2,T3,T4} for a phase.
  function automatic logic [9:0] exp_vec(input int p);
    case (p)
      P_IF1:   return 10'b0110100000;
      P_IF2:   return 10'b0110010000;
      P_EX1:   return 10'b0101001000;
      P_EX2:   return 10'b0101000100;
      P_EX3:   return 10'b0101000010;
      P_EX4:   return 10'b0101000001;
      P_FAULT: return 10'b1000000000;
      default: return 10'b0000000000;
    endcase
  endfunction

  function automatic logic [9:0] obs_vec();
    return {bus.fault, bus.busy, bus.Mif, bus.Mex, bus.T1_Mif, bus.T2_Mif,
            bus.T1, bus.T2, bus.T3, bus.T4};
  endfunction

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string tag, input logic [15:0] o, input logic [15:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask

  // Check the current phase, then apply the inputs seen at the coming edge.
  task automatic step(input bit r, input bit d, input bit m, input int p);
    check({pname[p], "_vec"}, {6'b0, obs_vec()}, {6'b0, exp_vec(p)});
    check({pname[p], "_count"}, bus.retired_count, model_cnt);
    bus.run         = r;
    bus.output_done = d;
    bus.mem_op      = m;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, rnd(), rnd(), P_IDLE);
    step(1'b1, rnd(), rnd(), P_IDLE);
  endtask

  // One whole instruction: dif/dex are the not-done cycles in the two waits,
  // r_end is run at the retiring cycle. Other inputs are noise.
  task automatic instr(input bit mem, input int dif, input int dex, input bit r_end);
    step(rnd(), rnd(), rnd(), P_IF1);
    for (int i = 0; i < dif; i++) step(rnd(), 1'b0, rnd(), P_IF2);
    step(rnd(), 1'b1, rnd(), P_IF2);
    if (!mem) begin
      step(r_end, rnd(), 1'b0, P_EX1);
      model_cnt = model_cnt + 16'd1;
    end else begin
      step(rnd(), rnd(), 1'b1, P_EX1);
      step(rnd(), rnd(), rnd(), P_EX2);
      for (int i = 0; i < dex; i++) step(rnd(), 1'b0, rnd(), P_EX3);
      step(rnd(), 1'b1, rnd(), P_EX3);
      step(r_end, rnd(), rnd(), P_EX4);
      model_cnt = model_cnt + 16'd1;
    end
  endtask

  task automatic reset_check(input string tag);
    rst = 1'b1;
    #1;
    model_cnt = 16'd0;
    check({tag, "_vec"}, {6'b0, obs_vec()}, 16'd0);
    check({tag, "_count"}, bus.retired_count, model_cnt);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.run         = 1'b0;
    bus.output_done = 1'b0;
    bus.mem_op      = 1'b0;
    #1;
    reset_check("reset");
    @(negedge clk);

    // Back-to-back non-memory instructions, then stop.
    idle(2);
    instr(1'b0, 0, 0, 1'b1);
    instr(1'b0, 0, 0, 1'b1);
    instr(1'b0, 0, 0, 1'b0);

    // Memory instruction with done on the third EX3 cycle.
    idle(1);
    instr(1'b1, 0, 2, 1'b0);

    // run dropped during execution: finish, idle, resume.
    idle(0);
    instr(1'b1, 1, 1, 1'b0);
    idle(2);

    // Done arriving on the last permitted IF2 cycle.
    instr(1'b0, 3, 0, 1'b1);

    // Randomized instruction stream.
    for (int k = 0; k < 40; k++) begin
      bit m, r;
      m = rnd();
      r = rnd();
      instr(m, $urandom_range(0, 3), $urandom_range(0, 3), r);
      if (!r) idle($urandom_range(0, 2));
    end
    instr(1'b1, 0, 3, 1'b0);

    // Counter wrap from a preset near the top.
    force dut.retired_count_q = 16'hFFFE;
    #1;
    release dut.retired_count_q;
    model_cnt = 16'hFFFE;
    idle(1);
    instr(1'b0, 0, 0, 1'b1);
    instr(1'b0, 0, 0, 1'b1);
    instr(1'b1, 1, 0, 1'b1);

    // Reset while waiting in EX3.
    step(rnd(), rnd(), rnd(), P_IF1);
    step(rnd(), 1'b1, rnd(), P_IF2);
    step(rnd(), rnd(), 1'b1, P_EX1);
    step(rnd(), rnd(), rnd(), P_EX2);
    step(rnd(), 1'b0, rnd(), P_EX3);
    reset_check("rst_ex3");

    // Timeout in IF2 is terminal until reset.
    idle(1);
    step(rnd(), rnd(), rnd(), P_IF1);
    for (int i = 0; i < 4; i++) step(rnd(), 1'b0, rnd(), P_IF2);
    for (int i = 0; i < 5; i++) step(rnd(), rnd(), rnd(), P_FAULT);
    reset_check("rst_fault");
    step(1'b0, rnd(), rnd(), P_IDLE);
    step(1'b0, rnd(), rnd(), P_IDLE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
